// File: rtl/guess_editor.sv
// guess_editor: cursor-based colour-code editor for a code-guessing game.
//
// The player edits four colour slots (codes 1..7, 0 means "off"), submits
// them to a scorer through a valid/ready handshake, and can browse the
// accepted guesses kept in a small circular history buffer.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   btn_left/right/color/      debounced single-cycle button pulses
//   submit/mode
//   game_over                  level, blocks further guesses
//   guess_ready                scorer accepts the offered guess
//   guess_valid, guess_code    offered guess {slot3,slot2,slot1,slot0}
//   guess_rgb0..3              edit-slot colours
//   history_rgb0..3            selected history entry (0 outside VIEW)
//   blink_enable               guess display with blinking cursor
//   blink_led                  cursor slot index
module guess_editor #(
  parameter int HIST_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_color,
  input  logic        btn_submit,
  input  logic        btn_mode,
  input  logic        game_over,
  input  logic        guess_ready,
  output logic        guess_valid,
  output logic [11:0] guess_code,
  output logic [2:0]  guess_rgb0,
  output logic [2:0]  guess_rgb1,
  output logic [2:0]  guess_rgb2,
  output logic [2:0]  guess_rgb3,
  output logic [2:0]  history_rgb0,
  output logic [2:0]  history_rgb1,
  output logic [2:0]  history_rgb2,
  output logic [2:0]  history_rgb3,
  output logic        blink_enable,
  output logic [1:0]  blink_led
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {EDIT, OFFER, VIEW, LOCKED} state_t;

  state_t           state;
  logic [2:0]       slot [4];
  logic [1:0]       cursor;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] view_idx;
  logic [CNT_W-1:0] hist_count;
  logic             view_from_lock;
  logic [11:0]      hist_word;
  logic [11:0]      hist_mem [HIST_DEPTH];
  logic             hist_we;
  logic             mv_left;
  logic             mv_right;

  // Colour cycles 1..7; 0 is never produced.
  function automatic logic [2:0] next_color(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

  // View index 0 is the newest entry, i.e. the one just behind wr_ptr.
  function automatic logic [11:0] entry(input logic [PTR_W-1:0] idx);
    return hist_mem[wr_ptr - PTR_W'(1) - idx];
  endfunction

  // Pressing both directions at once cancels the move.
  assign mv_left  = btn_left & ~btn_right;
  assign mv_right = btn_right & ~btn_left;

  // A reset forces state to EDIT asynchronously, so an aborted offer
  // can never reach the write below.
  assign hist_we = (state == OFFER) && guess_ready;

  always_ff @(posedge clk) begin
    if (hist_we) hist_mem[wr_ptr] <= guess_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= EDIT;
      for (int i = 0; i < 4; i++) slot[i] <= 3'd1;
      cursor         <= 2'd0;
      wr_ptr         <= '0;
      view_idx       <= '0;
      hist_count     <= '0;
      view_from_lock <= 1'b0;
      hist_word      <= 12'd0;
      guess_valid    <= 1'b0;
      guess_code     <= 12'd0;
      blink_enable   <= 1'b1;
    end else begin
      unique case (state)
        EDIT: begin
          if (game_over) begin
            state        <= LOCKED;
            blink_enable <= 1'b0;
          end else if (btn_submit) begin
            state       <= OFFER;
            guess_valid <= 1'b1;
            guess_code  <= {slot[3], slot[2], slot[1], slot[0]};
          end else if (btn_mode) begin
            // A mode press with no history is swallowed.
            if (hist_count != '0) begin
              state          <= VIEW;
              view_idx       <= '0;
              view_from_lock <= 1'b0;
              hist_word      <= entry('0);
              blink_enable   <= 1'b0;
            end
          end else if (btn_color) begin
            slot[cursor] <= next_color(slot[cursor]);
          end else if (mv_left) begin
            cursor <= cursor - 2'd1;
          end else if (mv_right) begin
            cursor <= cursor + 2'd1;
          end
        end

        OFFER: begin
          if (guess_ready) begin
            guess_valid <= 1'b0;
            wr_ptr      <= wr_ptr + PTR_W'(1);
            if (hist_count != CNT_W'(HIST_DEPTH))
              hist_count <= hist_count + CNT_W'(1);
            if (game_over) begin
              state        <= LOCKED;
              blink_enable <= 1'b0;
            end else begin
              state <= EDIT;
            end
          end
        end

        VIEW: begin
          if (btn_mode) begin
            state        <= view_from_lock ? LOCKED : EDIT;
            blink_enable <= ~view_from_lock;
            hist_word    <= 12'd0;
          end else if (game_over && !view_from_lock) begin
            state     <= LOCKED;
            hist_word <= 12'd0;
          end else if (mv_left && ({1'b0, view_idx} < hist_count - CNT_W'(1))) begin
            view_idx  <= view_idx + PTR_W'(1);
            hist_word <= entry(view_idx + PTR_W'(1));
          end else if (mv_right && view_idx != '0) begin
            view_idx  <= view_idx - PTR_W'(1);
            hist_word <= entry(view_idx - PTR_W'(1));
          end
        end

        LOCKED: begin
          if (btn_mode && hist_count != '0) begin
            state          <= VIEW;
            view_idx       <= '0;
            view_from_lock <= 1'b1;
            hist_word      <= entry('0);
          end
        end

        default: state <= EDIT;
      endcase
    end
  end

  assign guess_rgb0   = slot[0];
  assign guess_rgb1   = slot[1];
  assign guess_rgb2   = slot[2];
  assign guess_rgb3   = slot[3];
  assign history_rgb0 = hist_word[2:0];
  assign history_rgb1 = hist_word[5:3];
  assign history_rgb2 = hist_word[8:6];
  assign history_rgb3 = hist_word[11:9];
  assign blink_led    = cursor;

endmodule

// File: tb/tb_guess_editor.sv
module tb_guess_editor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_color = 1'b0;
  logic        btn_submit = 1'b0, btn_mode = 1'b0;
  logic        game_over = 1'b0, guess_ready = 1'b0;
  logic        guess_valid;
  logic [11:0] guess_code;
  logic [2:0]  guess_rgb0, guess_rgb1, guess_rgb2, guess_rgb3;
  logic [2:0]  history_rgb0, history_rgb1, history_rgb2, history_rgb3;
  logic        blink_enable;
  logic [1:0]  blink_led;

  int errors = 0;
  int checks = 0;

  localparam logic [4:0] B_L = 5'b00001;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_C = 5'b00100;
  localparam logic [4:0] B_S = 5'b01000;
  localparam logic [4:0] B_M = 5'b10000;

  typedef struct packed {
    logic [4:0]  btn;
    logic [11:0] code;
    logic [1:0]  led;
  } vec_t;

  vec_t tbl [22];

  guess_editor #(.HIST_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_left(btn_left), .btn_right(btn_right), .btn_color(btn_color),
    .btn_submit(btn_submit), .btn_mode(btn_mode),
    .game_over(game_over), .guess_ready(guess_ready),
    .guess_valid(guess_valid), .guess_code(guess_code),
    .guess_rgb0(guess_rgb0), .guess_rgb1(guess_rgb1),
    .guess_rgb2(guess_rgb2), .guess_rgb3(guess_rgb3),
    .history_rgb0(history_rgb0), .history_rgb1(history_rgb1),
    .history_rgb2(history_rgb2), .history_rgb3(history_rgb3),
    .blink_enable(blink_enable), .blink_led(blink_led)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] slots();
    return {guess_rgb3, guess_rgb2, guess_rgb1, guess_rgb0};
  endfunction

  function automatic logic [11:0] hist();
    return {history_rgb3, history_rgb2, history_rgb1, history_rgb0};
  endfunction

  function automatic logic [2:0] nc(input logic [2:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

  task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic [4:0] b);
    {btn_mode, btn_submit, btn_color, btn_right, btn_left} = b;
    @(posedge clk);
    #1;
    {btn_mode, btn_submit, btn_color, btn_right, btn_left} = 5'b0;
  endtask

  task automatic submit_accept();
    pulse(B_S);
    guess_ready = 1'b1;
    @(posedge clk);
    #1;
    guess_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [11:0] exp_g [10];
    logic [11:0] code0;
    logic [2:0]  s0, s1;
    int          vcount;
    logic        stable;

    tbl[0]  = '{B_C,       12'o1112, 2'd0};
    tbl[1]  = '{B_C,       12'o1113, 2'd0};
    tbl[2]  = '{B_C,       12'o1114, 2'd0};
    tbl[3]  = '{B_R,       12'o1114, 2'd1};
    tbl[4]  = '{B_C,       12'o1124, 2'd1};
    tbl[5]  = '{B_L,       12'o1124, 2'd0};
    tbl[6]  = '{B_L,       12'o1124, 2'd3};
    tbl[7]  = '{B_R,       12'o1124, 2'd0};
    tbl[8]  = '{B_C | B_L, 12'o1125, 2'd0};
    tbl[9]  = '{B_L | B_R, 12'o1125, 2'd0};
    tbl[10] = '{B_M,       12'o1125, 2'd0};
    tbl[11] = '{B_R,       12'o1125, 2'd1};
    tbl[12] = '{B_R,       12'o1125, 2'd2};
    tbl[13] = '{B_C,       12'o1225, 2'd2};
    tbl[14] = '{B_C,       12'o1325, 2'd2};
    tbl[15] = '{B_C,       12'o1425, 2'd2};
    tbl[16] = '{B_C,       12'o1525, 2'd2};
    tbl[17] = '{B_C,       12'o1625, 2'd2};
    tbl[18] = '{B_C,       12'o1725, 2'd2};
    tbl[19] = '{B_C,       12'o1125, 2'd2};
    tbl[20] = '{B_R,       12'o1125, 2'd3};
    tbl[21] = '{B_R,       12'o1125, 2'd0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 12'(guess_valid), 12'd0);
    chk("rst_code", guess_code, 12'd0);
    chk("rst_slots", slots(), 12'o1111);
    chk("rst_hist", hist(), 12'd0);
    chk("rst_blink", 12'(blink_enable), 12'd1);
    chk("rst_led", 12'(blink_led), 12'd0);
    rst_n = 1'b1;

    // Editing vectors
    for (int i = 0; i < 22; i++) begin
      pulse(tbl[i].btn);
      chk($sformatf("vec%0d_slots", i), slots(), tbl[i].code);
      chk($sformatf("vec%0d_led", i), 12'(blink_led), 12'(tbl[i].led));
      chk($sformatf("vec%0d_blink", i), 12'(blink_enable), 12'd1);
      chk($sformatf("vec%0d_valid", i), 12'(guess_valid), 12'd0);
      chk($sformatf("vec%0d_hist", i), hist(), 12'd0);
    end

    // Offer held 5 cycles, accepted on the 6th; color press ignored meanwhile
    pulse(B_S);
    vcount = guess_valid ? 1 : 0;
    code0  = guess_code;
    stable = 1'b1;
    chk("offer_code", guess_code, 12'o1125);
    for (int k = 1; k < 12; k++) begin
      guess_ready = (k == 6);
      btn_color   = (k == 2);
      @(posedge clk);
      #1;
      guess_ready = 1'b0;
      btn_color   = 1'b0;
      if (guess_valid) begin
        vcount++;
        if (guess_code !== code0) stable = 1'b0;
      end
    end
    chk("offer_valid_cycles", 12'(vcount), 12'd6);
    chk("offer_code_stable", 12'(stable), 12'd1);
    chk("offer_slots_kept", slots(), 12'o1125);
    pulse(B_M);
    chk("view1_hist", hist(), 12'o1125);
    chk("view1_blink", 12'(blink_enable), 12'd0);
    pulse(B_L);
    chk("view1_clamp", hist(), 12'o1125);
    pulse(B_M);
    chk("view1_exit_hist", hist(), 12'd0);
    chk("view1_exit_blink", 12'(blink_enable), 12'd1);

    // Ten guesses into an 8-deep history
    do_reset();
    s0 = 3'd1;
    s1 = 3'd1;
    for (int g = 0; g < 10; g++) begin
      pulse(B_C);
      s0 = nc(s0);
      if (g >= 5) begin
        pulse(B_R);
        pulse(B_C);
        s1 = nc(s1);
        pulse(B_L);
      end
      exp_g[g] = {3'd1, 3'd1, s1, s0};
      submit_accept();
    end
    pulse(B_M);
    chk("hist_newest", hist(), exp_g[9]);
    chk("hist_view_blink", 12'(blink_enable), 12'd0);
    for (int i = 1; i <= 7; i++) begin
      pulse(B_L);
      chk($sformatf("hist_older%0d", i), hist(), exp_g[9-i]);
    end
    pulse(B_L);
    chk("hist_oldest_clamp", hist(), exp_g[2]);
    pulse(B_R);
    chk("hist_newer", hist(), exp_g[3]);
    pulse(B_M);
    chk("hist_exit", hist(), 12'd0);

    // game_over during an offer: handshake finishes, then locked
    pulse(B_C);
    pulse(B_S);
    game_over = 1'b1;
    @(posedge clk);
    #1;
    chk("go_offer_held", 12'(guess_valid), 12'd1);
    chk("go_offer_code", guess_code, 12'o1165);
    guess_ready = 1'b1;
    @(posedge clk);
    #1;
    guess_ready = 1'b0;
    chk("go_valid_drop", 12'(guess_valid), 12'd0);
    chk("go_locked_blink", 12'(blink_enable), 12'd0);
    pulse(B_S);
    chk("locked_no_submit", 12'(guess_valid), 12'd0);
    pulse(B_C);
    chk("locked_no_color", slots(), 12'o1165);
    pulse(B_M);
    chk("locked_view_newest", hist(), 12'o1165);
    chk("locked_view_blink", 12'(blink_enable), 12'd0);
    pulse(B_L);
    chk("locked_view_older", hist(), exp_g[9]);
    pulse(B_M);
    chk("locked_return_hist", hist(), 12'd0);
    chk("locked_return_blink", 12'(blink_enable), 12'd0);
    game_over = 1'b0;

    // Reset mid-offer
    do_reset();
    pulse(B_S);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 12'(guess_valid), 12'd0);
    chk("rst_mid_blink", 12'(blink_enable), 12'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulse(B_M);
    chk("rst_mid_empty_blink", 12'(blink_enable), 12'd1);
    chk("rst_mid_empty_hist", hist(), 12'd0);

    // game_over in EDIT locks; mode with empty history stays locked
    game_over = 1'b1;
    @(posedge clk);
    #1;
    chk("edit_lock_blink", 12'(blink_enable), 12'd0);
    pulse(B_M);
    chk("lock_empty_mode", 12'(blink_enable), 12'd0);
    chk("lock_empty_hist", hist(), 12'd0);
    game_over = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
